// File: rtl/eve_dispatcher.sv
// Event/command dispatcher: splits a merged event stream into cd/cu FIFOs
// with per-channel drop filtering, and round-robin merges cd/cu commands.

module eve_dispatcher_fifo #(
  parameter int DATA_W     = 128,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              empty_o,
  output logic              full_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO never accepts, even if it is popped in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

module eve_dispatcher #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic         user_clk,
  input  logic         reset_n,
  input  logic         s_axis_transfer_eve_tvalid,
  input  logic [127:0] s_axis_transfer_eve_tdata,
  output logic         s_axis_transfer_eve_tready,
  output logic         m_axis_cd_transfer_eve_tvalid,
  output logic [127:0] m_axis_cd_transfer_eve_tdata,
  input  logic         m_axis_cd_transfer_eve_tready,
  output logic         m_axis_cu_transfer_eve_tvalid,
  output logic [127:0] m_axis_cu_transfer_eve_tdata,
  input  logic         m_axis_cu_transfer_eve_tready,
  input  logic         s_axis_cd_transfer_cmd_tvalid,
  input  logic [63:0]  s_axis_cd_transfer_cmd_tdata,
  output logic         s_axis_cd_transfer_cmd_tready,
  input  logic         s_axis_cu_transfer_cmd_tvalid,
  input  logic [63:0]  s_axis_cu_transfer_cmd_tdata,
  output logic         s_axis_cu_transfer_cmd_tready,
  output logic         m_axis_transfer_cmd_tvalid,
  output logic [63:0]  m_axis_transfer_cmd_tdata,
  input  logic         m_axis_transfer_cmd_tready,
  input  logic [7:0]   dma_rx_ch_connection_enable,
  input  logic [7:0]   dma_tx_ch_connection_enable,
  output logic [15:0]  cd_eve_drop_cnt,
  output logic [15:0]  cu_eve_drop_cnt
);
  localparam int EVE_W = 128;
  localparam int CMD_W = 64;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic       eve_dir, eve_ch_en, eve_accept;
  logic [2:0] eve_ch;
  logic       cd_push, cu_push;
  logic       cd_empty, cd_full, cu_empty, cu_full;
  logic       cd_pop, cu_pop;
  logic [15:0] cd_drop_q, cd_drop_d, cu_drop_q, cu_drop_d;

  assign eve_dir   = s_axis_transfer_eve_tdata[127];
  assign eve_ch    = s_axis_transfer_eve_tdata[2:0];
  assign eve_ch_en = eve_dir ? dma_tx_ch_connection_enable[eve_ch]
                             : dma_rx_ch_connection_enable[eve_ch];

  // Ready only looks at FIFO occupancy so it never waits on the routing decision.
  assign s_axis_transfer_eve_tready = reset_n && !cd_full && !cu_full;
  assign eve_accept = s_axis_transfer_eve_tvalid && s_axis_transfer_eve_tready;
  assign cd_push    = eve_accept && !eve_dir && eve_ch_en;
  assign cu_push    = eve_accept &&  eve_dir && eve_ch_en;

  always_comb begin
    cd_drop_d = cd_drop_q;
    cu_drop_d = cu_drop_q;
    if (eve_accept && !eve_ch_en) begin
      if (eve_dir) cu_drop_d = sat_inc(cu_drop_q);
      else         cd_drop_d = sat_inc(cd_drop_q);
    end
  end

  always_ff @(posedge user_clk) begin
    if (!reset_n) begin
      cd_drop_q <= '0;
      cu_drop_q <= '0;
    end else begin
      cd_drop_q <= cd_drop_d;
      cu_drop_q <= cu_drop_d;
    end
  end

  assign cd_eve_drop_cnt = cd_drop_q;
  assign cu_eve_drop_cnt = cu_drop_q;

  assign m_axis_cd_transfer_eve_tvalid = reset_n && !cd_empty;
  assign m_axis_cu_transfer_eve_tvalid = reset_n && !cu_empty;
  assign cd_pop = m_axis_cd_transfer_eve_tvalid && m_axis_cd_transfer_eve_tready;
  assign cu_pop = m_axis_cu_transfer_eve_tvalid && m_axis_cu_transfer_eve_tready;

  eve_dispatcher_fifo #(.DATA_W(EVE_W), .FIFO_DEPTH(FIFO_DEPTH)) u_cd_fifo (
    .clk_i   (user_clk),
    .rst_n_i (reset_n),
    .push_i  (cd_push),
    .data_i  (s_axis_transfer_eve_tdata),
    .pop_i   (cd_pop),
    .data_o  (m_axis_cd_transfer_eve_tdata),
    .empty_o (cd_empty),
    .full_o  (cd_full)
  );

  eve_dispatcher_fifo #(.DATA_W(EVE_W), .FIFO_DEPTH(FIFO_DEPTH)) u_cu_fifo (
    .clk_i   (user_clk),
    .rst_n_i (reset_n),
    .push_i  (cu_push),
    .data_i  (s_axis_transfer_eve_tdata),
    .pop_i   (cu_pop),
    .data_o  (m_axis_cu_transfer_eve_tdata),
    .empty_o (cu_empty),
    .full_o  (cu_full)
  );

  logic             rr_q, rr_d;
  logic             grant_cd, grant_cu, cmd_push, cmd_pop;
  logic             cmd_empty, cmd_full;
  logic [CMD_W-1:0] cmd_word;

  // rr_q = 0 prefers cd, 1 prefers cu; the loser of a contested cycle wins next.
  always_comb begin
    grant_cd = 1'b0;
    grant_cu = 1'b0;
    if (reset_n && !cmd_full) begin
      if (!rr_q) begin
        if (s_axis_cd_transfer_cmd_tvalid)      grant_cd = 1'b1;
        else if (s_axis_cu_transfer_cmd_tvalid) grant_cu = 1'b1;
      end else begin
        if (s_axis_cu_transfer_cmd_tvalid)      grant_cu = 1'b1;
        else if (s_axis_cd_transfer_cmd_tvalid) grant_cd = 1'b1;
      end
    end
  end

  assign s_axis_cd_transfer_cmd_tready = grant_cd;
  assign s_axis_cu_transfer_cmd_tready = grant_cu;
  assign cmd_push = grant_cd || grant_cu;

  always_comb begin
    cmd_word     = grant_cu ? s_axis_cu_transfer_cmd_tdata : s_axis_cd_transfer_cmd_tdata;
    cmd_word[63] = grant_cu;
    rr_d = rr_q;
    if (grant_cd)      rr_d = 1'b1;
    else if (grant_cu) rr_d = 1'b0;
  end

  always_ff @(posedge user_clk) begin
    if (!reset_n) rr_q <= 1'b0;
    else          rr_q <= rr_d;
  end

  assign m_axis_transfer_cmd_tvalid = reset_n && !cmd_empty;
  assign cmd_pop = m_axis_transfer_cmd_tvalid && m_axis_transfer_cmd_tready;

  eve_dispatcher_fifo #(.DATA_W(CMD_W), .FIFO_DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .clk_i   (user_clk),
    .rst_n_i (reset_n),
    .push_i  (cmd_push),
    .data_i  (cmd_word),
    .pop_i   (cmd_pop),
    .data_o  (m_axis_transfer_cmd_tdata),
    .empty_o (cmd_empty),
    .full_o  (cmd_full)
  );
endmodule
